// File: rtl/exc_ctrl_if.sv
// ---------------------------------------------------------------------------
// Module  : exc_ctrl_if
// Purpose : Pipeline/CP0 bundle between the MIPS core and exc_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface exc_ctrl_if;
    logic        mem_valid_i;
    logic        stall_i;
    logic [6:0]  exc_flags_i;
    logic [31:0] exc_pc_i;
    logic        exc_in_delay_i;
    logic [31:0] exc_badaddr_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  int_i;
    logic        timer_int_i;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        cp0_epc_we_o;
    logic        cp0_cause_we_o;
    logic        cp0_status_we_o;
    logic        cp0_badvaddr_we_o;
    logic [31:0] cp0_epc_o;
    logic [31:0] cp0_cause_o;
    logic [31:0] cp0_status_o;
    logic [31:0] cp0_badvaddr_o;
    logic        busy_o;

    modport slave (
        input  mem_valid_i, stall_i, exc_flags_i, exc_pc_i, exc_in_delay_i,
               exc_badaddr_i, cp0_status_i, cp0_cause_i, cp0_epc_i, int_i, timer_int_i,
        output flush_o, new_pc_o, cp0_epc_we_o, cp0_cause_we_o, cp0_status_we_o,
               cp0_badvaddr_we_o, cp0_epc_o, cp0_cause_o, cp0_status_o, cp0_badvaddr_o, busy_o
    );

    modport master (
        output mem_valid_i, stall_i, exc_flags_i, exc_pc_i, exc_in_delay_i,
               exc_badaddr_i, cp0_status_i, cp0_cause_i, cp0_epc_i, int_i, timer_int_i,
        input  flush_o, new_pc_o, cp0_epc_we_o, cp0_cause_we_o, cp0_status_we_o,
               cp0_badvaddr_we_o, cp0_epc_o, cp0_cause_o, cp0_status_o, cp0_badvaddr_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/exc_ctrl.sv
// ---------------------------------------------------------------------------
// Module  : exc_ctrl
// Purpose : Precise exception / interrupt arbiter with CP0 write-back and ERET
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    exc_ctrl_if.slave   bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COMMIT = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [3:0] C_DRAIN_LOAD = (FLUSH_CYCLES >= 2) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  sync1_q, sync2_q;

    logic        flush_q, flush_d;
    logic        busy_q, busy_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic        epc_we_q, epc_we_d;
    logic        cause_we_q, cause_we_d;
    logic        status_we_q, status_we_d;
    logic        badvaddr_we_q, badvaddr_we_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] status_q, status_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic [5:0]  ip;
    logic        int_pend;
    logic        take;
    logic        is_eret;
    logic        is_addr_err;
    logic [4:0]  exc_code;

    // ip[7:2] of the Cause register; the timer shares line 5 with hardware int 5
    assign ip       = {sync2_q[5] | bus.timer_int_i, sync2_q[4:0]};
    assign int_pend = (|(ip & bus.cp0_status_i[15:10])) & bus.cp0_status_i[0] & ~bus.cp0_status_i[1];
    assign take     = (state_q == S_IDLE) & bus.mem_valid_i & ~bus.stall_i
                    & (int_pend | (|bus.exc_flags_i));

    always_comb begin
        is_eret     = 1'b0;
        is_addr_err = 1'b0;
        exc_code    = 5'h00;
        if (int_pend) begin
            exc_code = 5'h00;
        end else if (bus.exc_flags_i[0]) begin
            exc_code    = 5'h04;
            is_addr_err = 1'b1;
        end else if (bus.exc_flags_i[1]) begin
            exc_code = 5'h0A;
        end else if (bus.exc_flags_i[2]) begin
            exc_code = 5'h0C;
        end else if (bus.exc_flags_i[3]) begin
            exc_code = 5'h08;
        end else if (bus.exc_flags_i[4]) begin
            exc_code = 5'h09;
        end else if (bus.exc_flags_i[5]) begin
            exc_code    = 5'h05;
            is_addr_err = 1'b1;
        end else begin
            is_eret = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            sync1_q <= 6'd0;
            sync2_q <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync1_q <= bus.int_i;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (take) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                if (FLUSH_CYCLES > 1) begin
                    state_d = S_DRAIN;
                    cnt_d   = C_DRAIN_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (cnt_q == 4'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the next cycle; strobes are one-cycle pulses on the take
    always_comb begin
        flush_d       = (state_d != S_IDLE);
        busy_d        = flush_d;
        new_pc_d      = flush_d ? new_pc_q : 32'd0;
        epc_we_d      = 1'b0;
        cause_we_d    = 1'b0;
        status_we_d   = 1'b0;
        badvaddr_we_d = 1'b0;
        epc_d         = 32'd0;
        cause_d       = 32'd0;
        status_d      = 32'd0;
        badvaddr_d    = 32'd0;
        if (take) begin
            status_we_d = 1'b1;
            if (is_eret) begin
                new_pc_d = bus.cp0_epc_i;
                status_d = bus.cp0_status_i & ~32'h2;
            end else begin
                new_pc_d   = EXC_VECTOR;
                epc_we_d   = 1'b1;
                epc_d      = bus.exc_in_delay_i ? (bus.exc_pc_i - 32'd4) : bus.exc_pc_i;
                cause_we_d = 1'b1;
                cause_d    = (bus.cp0_cause_i & ~32'h8000_007C)
                           | {bus.exc_in_delay_i, 24'd0, exc_code, 2'b00};
                status_d   = bus.cp0_status_i | 32'h2;
                if (is_addr_err) begin
                    badvaddr_we_d = 1'b1;
                    badvaddr_d    = bus.exc_badaddr_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
            new_pc_q      <= 32'd0;
            epc_we_q      <= 1'b0;
            cause_we_q    <= 1'b0;
            status_we_q   <= 1'b0;
            badvaddr_we_q <= 1'b0;
            epc_q         <= 32'd0;
            cause_q       <= 32'd0;
            status_q      <= 32'd0;
            badvaddr_q    <= 32'd0;
        end else begin
            flush_q       <= flush_d;
            busy_q        <= busy_d;
            new_pc_q      <= new_pc_d;
            epc_we_q      <= epc_we_d;
            cause_we_q    <= cause_we_d;
            status_we_q   <= status_we_d;
            badvaddr_we_q <= badvaddr_we_d;
            epc_q         <= epc_d;
            cause_q       <= cause_d;
            status_q      <= status_d;
            badvaddr_q    <= badvaddr_d;
        end
    end

    assign bus.flush_o           = flush_q;
    assign bus.busy_o            = busy_q;
    assign bus.new_pc_o          = new_pc_q;
    assign bus.cp0_epc_we_o      = epc_we_q;
    assign bus.cp0_cause_we_o    = cause_we_q;
    assign bus.cp0_status_we_o   = status_we_q;
    assign bus.cp0_badvaddr_we_o = badvaddr_we_q;
    assign bus.cp0_epc_o         = epc_q;
    assign bus.cp0_cause_o       = cause_q;
    assign bus.cp0_status_o      = status_q;
    assign bus.cp0_badvaddr_o    = badvaddr_q;

endmodule

`default_nettype wire

// File: tb/tb_exc_ctrl.sv
// ---------------------------------------------------------------------------
// Module  : tb_exc_ctrl
// Purpose : Directed and randomized self-checking bench for exc_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_exc_ctrl;

    localparam logic [31:0] C_VEC   = 32'hBFC00380;
    localparam int          C_FLUSH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    exc_ctrl_if bus();

    exc_ctrl #(.EXC_VECTOR(C_VEC), .FLUSH_CYCLES(C_FLUSH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model state: cycles of flush left, and int_i as seen one/two edges ago
    int          m_cnt;
    logic [5:0]  m_p1, m_p2;
    logic [31:0] m_newpc, m_epc, m_cause, m_status, m_badv;
    logic        m_epc_we, m_cause_we, m_status_we, m_badv_we;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.mem_valid_i    = 1'b0;
        bus.stall_i        = 1'b0;
        bus.exc_flags_i    = 7'd0;
        bus.exc_pc_i       = 32'd0;
        bus.exc_in_delay_i = 1'b0;
        bus.exc_badaddr_i  = 32'd0;
        bus.cp0_status_i   = 32'd0;
        bus.cp0_cause_i    = 32'd0;
        bus.cp0_epc_i      = 32'd0;
        bus.int_i          = 6'd0;
        bus.timer_int_i    = 1'b0;
    endtask

    function automatic logic [165:0] dut_bundle();
        return {bus.flush_o, bus.busy_o, bus.new_pc_o, bus.cp0_epc_we_o, bus.cp0_cause_we_o,
                bus.cp0_status_we_o, bus.cp0_badvaddr_we_o, bus.cp0_epc_o, bus.cp0_cause_o,
                bus.cp0_status_o, bus.cp0_badvaddr_o};
    endfunction

    function automatic logic [165:0] model_bundle();
        return {(m_cnt > 0), (m_cnt > 0), m_newpc, m_epc_we, m_cause_we, m_status_we, m_badv_we,
                m_epc, m_cause, m_status, m_badv};
    endfunction

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_edge();
        int unsigned codes[6] = '{4, 10, 12, 8, 9, 5};
        logic [5:0] ipv;
        logic pend;
        int sel;
        {m_epc_we, m_cause_we, m_status_we, m_badv_we} = 4'd0;
        {m_epc, m_cause, m_status, m_badv} = 128'd0;
        if (rst) begin
            m_cnt = 0; m_newpc = 0; m_p1 = 0; m_p2 = 0;
        end else begin
            ipv  = {m_p2[5] | bus.timer_int_i, m_p2[4:0]};
            pend = ((ipv & bus.cp0_status_i[15:10]) != 0) && bus.cp0_status_i[0] && !bus.cp0_status_i[1];
            if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) m_newpc = 0;
            end else if (bus.mem_valid_i && !bus.stall_i && (pend || bus.exc_flags_i != 0)) begin
                m_cnt = C_FLUSH;
                m_status_we = 1'b1;
                sel = -1;
                for (int i = 5; i >= 0; i--) if (bus.exc_flags_i[i]) sel = i;
                if (!pend && sel < 0) begin
                    m_newpc  = bus.cp0_epc_i;
                    m_status = bus.cp0_status_i & 32'hFFFF_FFFD;
                end else begin
                    m_newpc    = C_VEC;
                    m_epc_we   = 1'b1;
                    m_cause_we = 1'b1;
                    m_epc      = bus.exc_pc_i - (bus.exc_in_delay_i ? 32'd4 : 32'd0);
                    m_cause    = bus.cp0_cause_i;
                    m_cause[31]  = bus.exc_in_delay_i;
                    m_cause[6:2] = pend ? 5'd0 : 5'(codes[sel]);
                    m_status   = bus.cp0_status_i | 32'd2;
                    if (!pend && (sel == 0 || sel == 5)) begin
                        m_badv_we = 1'b1;
                        m_badv    = bus.exc_badaddr_i;
                    end
                end
            end else begin
                m_newpc = 0;
            end
            m_p2 = m_p1;
            m_p1 = bus.int_i;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        bus.mem_valid_i = 1'b1;
        bus.exc_flags_i = 7'b0000100;
        tick(); tick();
        checks++; if (dut_bundle() !== 166'd0) begin errors++; $display("FAIL reset_outputs: got %h exp 0", dut_bundle()); end
        rst = 1'b0;
        clear_inputs();
        tick();
    endtask

    task automatic test_overflow();
        clear_inputs();
        bus.cp0_status_i = 32'h1000_0001;
        bus.exc_pc_i     = 32'h8000_0100;
        bus.mem_valid_i  = 1'b1;
        bus.exc_flags_i  = 7'b0000100;
        tick();
        checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL ov_flush: got %b exp 1", bus.flush_o); end
        checks++; if (bus.new_pc_o !== C_VEC) begin errors++; $display("FAIL ov_new_pc: got %h exp %h", bus.new_pc_o, C_VEC); end
        checks++; if ({bus.cp0_epc_we_o, bus.cp0_epc_o} !== {1'b1, 32'h8000_0100}) begin errors++; $display("FAIL ov_epc: got %b/%h exp 1/80000100", bus.cp0_epc_we_o, bus.cp0_epc_o); end
        checks++; if ({bus.cp0_cause_we_o, bus.cp0_cause_o[6:2]} !== {1'b1, 5'h0C}) begin errors++; $display("FAIL ov_cause: got %b/%h exp 1/0c", bus.cp0_cause_we_o, bus.cp0_cause_o[6:2]); end
        checks++; if ({bus.cp0_status_we_o, bus.cp0_status_o} !== {1'b1, 32'h1000_0003}) begin errors++; $display("FAIL ov_status: got %b/%h exp 1/10000003", bus.cp0_status_we_o, bus.cp0_status_o); end
        checks++; if (bus.cp0_badvaddr_we_o !== 1'b0) begin errors++; $display("FAIL ov_badv_we: got %b exp 0", bus.cp0_badvaddr_we_o); end
        bus.mem_valid_i = 1'b0;
        bus.exc_flags_i = 7'd0;
        tick();
        checks++; if ({bus.flush_o, bus.busy_o, bus.cp0_epc_we_o, bus.new_pc_o} !== {3'b110, C_VEC}) begin errors++; $display("FAIL ov_drain: got %b%b%b/%h exp 110/%h", bus.flush_o, bus.busy_o, bus.cp0_epc_we_o, bus.new_pc_o, C_VEC); end
        tick();
        checks++; if ({bus.flush_o, bus.busy_o} !== 2'b00) begin errors++; $display("FAIL ov_idle: got %b%b exp 00", bus.flush_o, bus.busy_o); end
    endtask

    task automatic test_syscall_delay();
        clear_inputs();
        bus.exc_pc_i       = 32'h8000_0204;
        bus.exc_in_delay_i = 1'b1;
        bus.mem_valid_i    = 1'b1;
        bus.exc_flags_i    = 7'b0001000;
        tick();
        checks++; if (bus.cp0_epc_o !== 32'h8000_0200) begin errors++; $display("FAIL sys_epc: got %h exp 80000200", bus.cp0_epc_o); end
        checks++; if ({bus.cp0_cause_o[31], bus.cp0_cause_o[6:2]} !== {1'b1, 5'h08}) begin errors++; $display("FAIL sys_cause: got %b/%h exp 1/08", bus.cp0_cause_o[31], bus.cp0_cause_o[6:2]); end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_int_priority();
        clear_inputs();
        bus.cp0_status_i = 32'h0000_1001;
        bus.int_i        = 6'b000100;
        tick(); tick();
        bus.mem_valid_i = 1'b1;
        bus.exc_flags_i = 7'b0000010;
        tick();
        checks++; if ({bus.cp0_cause_we_o, bus.cp0_cause_o[6:2], bus.cp0_badvaddr_we_o} !== {1'b1, 5'h00, 1'b0}) begin errors++; $display("FAIL int_wins: got %b/%h/%b exp 1/00/0", bus.cp0_cause_we_o, bus.cp0_cause_o[6:2], bus.cp0_badvaddr_we_o); end
        bus.mem_valid_i = 1'b0;
        tick(); tick();
        bus.cp0_status_i = 32'h0000_1003;
        bus.mem_valid_i  = 1'b1;
        tick();
        checks++; if ({bus.cp0_cause_we_o, bus.cp0_cause_o[6:2]} !== {1'b1, 5'h0A}) begin errors++; $display("FAIL ri_exl: got %b/%h exp 1/0a", bus.cp0_cause_we_o, bus.cp0_cause_o[6:2]); end
        clear_inputs();
        tick(); tick(); tick();
    endtask

    task automatic test_eret();
        clear_inputs();
        bus.cp0_status_i = 32'h0000_FF03;
        bus.cp0_epc_i    = 32'h8000_0400;
        bus.mem_valid_i  = 1'b1;
        bus.exc_flags_i  = 7'b1000000;
        tick();
        checks++; if (bus.new_pc_o !== 32'h8000_0400) begin errors++; $display("FAIL eret_pc: got %h exp 80000400", bus.new_pc_o); end
        checks++; if ({bus.cp0_status_we_o, bus.cp0_status_o} !== {1'b1, 32'h0000_FF01}) begin errors++; $display("FAIL eret_status: got %b/%h exp 1/0000ff01", bus.cp0_status_we_o, bus.cp0_status_o); end
        checks++; if ({bus.cp0_epc_we_o, bus.cp0_cause_we_o, bus.cp0_badvaddr_we_o} !== 3'b000) begin errors++; $display("FAIL eret_strobes: got %b%b%b exp 000", bus.cp0_epc_we_o, bus.cp0_cause_we_o, bus.cp0_badvaddr_we_o); end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_ades_stall();
        clear_inputs();
        bus.exc_badaddr_i = 32'h0000_0003;
        bus.mem_valid_i   = 1'b1;
        bus.stall_i       = 1'b1;
        bus.exc_flags_i   = 7'b0100000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({bus.busy_o, bus.cp0_epc_we_o, bus.cp0_cause_we_o, bus.cp0_status_we_o, bus.cp0_badvaddr_we_o} !== 5'd0) begin errors++; $display("FAIL ades_stalled: got %b%b%b%b%b exp 00000", bus.busy_o, bus.cp0_epc_we_o, bus.cp0_cause_we_o, bus.cp0_status_we_o, bus.cp0_badvaddr_we_o); end
        end
        bus.stall_i = 1'b0;
        tick();
        checks++; if ({bus.cp0_badvaddr_we_o, bus.cp0_badvaddr_o, bus.cp0_cause_o[6:2]} !== {1'b1, 32'h3, 5'h05}) begin errors++; $display("FAIL ades_commit: got %b/%h/%h exp 1/00000003/05", bus.cp0_badvaddr_we_o, bus.cp0_badvaddr_o, bus.cp0_cause_o[6:2]); end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_rst_drain();
        clear_inputs();
        bus.mem_valid_i = 1'b1;
        bus.exc_flags_i = 7'b0001000;
        tick();
        clear_inputs();
        tick();
        checks++; if ({bus.flush_o, bus.busy_o} !== 2'b11) begin errors++; $display("FAIL rst_pre_drain: got %b%b exp 11", bus.flush_o, bus.busy_o); end
        rst = 1'b1;
        tick();
        checks++; if ({bus.flush_o, bus.busy_o} !== 2'b00) begin errors++; $display("FAIL rst_drain: got %b%b exp 00", bus.flush_o, bus.busy_o); end
        bus.mem_valid_i = 1'b1;
        bus.exc_flags_i = 7'b0000100;
        tick();
        checks++; if (dut_bundle() !== 166'd0) begin errors++; $display("FAIL rst_no_write: got %h exp 0", dut_bundle()); end
        rst = 1'b0;
        bus.exc_flags_i = 7'b0001000;
        tick();
        checks++; if ({bus.flush_o, bus.cp0_cause_we_o, bus.cp0_cause_o[6:2]} !== {2'b11, 5'h08}) begin errors++; $display("FAIL rst_retake: got %b%b/%h exp 11/08", bus.flush_o, bus.cp0_cause_we_o, bus.cp0_cause_o[6:2]); end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_random();
        logic [165:0] exp_v;
        clear_inputs();
        rst = 1'b1;
        model_edge();
        tick();
        for (int n = 0; n < 2000; n++) begin
            rst             = ($urandom_range(0, 99) == 0);
            bus.mem_valid_i = ($urandom_range(0, 3) != 0);
            bus.stall_i     = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       bus.exc_flags_i = 7'd0;
                1:       bus.exc_flags_i = 7'd1 << $urandom_range(0, 6);
                default: bus.exc_flags_i = 7'($urandom);
            endcase
            bus.exc_pc_i       = $urandom;
            bus.exc_in_delay_i = 1'($urandom_range(0, 1));
            bus.exc_badaddr_i  = $urandom;
            bus.cp0_status_i   = $urandom;
            if ($urandom_range(0, 1) == 0) bus.cp0_status_i = (bus.cp0_status_i | 32'h1) & ~32'h2;
            bus.cp0_cause_i    = $urandom;
            bus.cp0_epc_i      = $urandom;
            if ($urandom_range(0, 7) == 0) bus.int_i = 6'($urandom);
            bus.timer_int_i    = ($urandom_range(0, 15) == 0);
            model_edge();
            exp_v = model_bundle();
            tick();
            checks++; if (dut_bundle() !== exp_v) begin errors++; $display("FAIL random_cycle%0d: got %h exp %h", n, dut_bundle(), exp_v); end
        end
        rst = 1'b0;
        clear_inputs();
        tick(); tick(); tick();
    endtask

    initial begin
        m_cnt = 0; m_p1 = 0; m_p2 = 0; m_newpc = 0;
        test_reset();
        test_overflow();
        test_syscall_delay();
        test_int_priority();
        test_eret();
        test_ades_stall();
        test_rst_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Precise-exception and interrupt controller for the 5-stage MIPS core. It consumes CP0 state (Status, Cause, EPC) and MEM-stage exception flags, and arbitrates one exception or interrupt per commit. It then writes back the CP0 fields it owns (EPC, Cause.BD/ExcCode, Status.EXL, BadVAddr), flushes the pipeline and redirects fetch. It also handles ERET: it clears EXL and returns to EPC.

Parameters:
EXC_VECTOR, 32'hBFC00380, general exception entry PC
FLUSH_CYCLES, 2, total cycles flush_o stays high per event (1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high (RstEnable)
mem_valid_i  in  1  MEM-stage holds a real instruction
stall_i  in  1  pipeline stalled this cycle
exc_flags_i  in  7  {eret, ades, break, syscall, ov, ri, adel_if}, one-hot or multi-hot
exc_pc_i  in  32  PC of MEM-stage instruction
exc_in_delay_i  in  1  instruction sits in a branch delay slot
exc_badaddr_i  in  32  faulting address for AdEL/AdES
cp0_status_i  in  32  current Status (forwarded)
cp0_cause_i  in  32  current Cause (forwarded)
cp0_epc_i  in  32  current EPC (forwarded)
int_i  in  6  asynchronous hardware interrupt lines
timer_int_i  in  1  CP0 timer interrupt
flush_o  out  1  kill IF..MEM contents
new_pc_o  out  32  fetch redirect target, valid while flush_o
cp0_epc_we_o / cp0_cause_we_o / cp0_status_we_o / cp0_badvaddr_we_o  out  1 each  CP0 write strobes
cp0_epc_o, cp0_cause_o, cp0_status_o, cp0_badvaddr_o  out  32 each  CP0 write data
busy_o  out  1  FSM not IDLE

Behaviour:
- Reset: all outputs 0, FSM=IDLE, synchronizers cleared.
- int_i passes through a 2-flop synchronizer, so latency is 2 cycles. ip[7:2] = {sync[5]|timer_int_i, sync[4:0]}.
- int_pend = |(ip & status[15:10]) & status[0](IE) & ~status[1](EXL).
- Take condition (IDLE only): mem_valid_i & ~stall_i & (int_pend | |exc_flags_i).
- Priority, highest first: Int(0x00) > adel_if(0x04) > ri(0x0A) > ov(0x0C) > syscall(0x08) > break(0x09) > ades(0x05) > eret. Exactly one event is taken per commit.
- FSM states: IDLE -> COMMIT (1 cycle) -> DRAIN (FLUSH_CYCLES-1 cycles) -> IDLE.
- All outputs are registered. The strobes assert in the cycle after the take condition is sampled.
- COMMIT for an exception or interrupt:
  - flush_o=1, new_pc_o=EXC_VECTOR.
  - epc_we=1, epc_o = in_delay ? pc-4 : pc (mod 2^32).
  - cause_we=1, cause_o = cause_i with [31]=in_delay and [6:2]=ExcCode; all other bits unchanged.
  - status_we=1, status_o = status_i | 32'h2.
  - badvaddr_we=1 only for AdEL/AdES; badvaddr_o=badaddr_i, else 0.
- COMMIT for ERET: flush_o=1, new_pc_o=epc_i, status_we=1, status_o = status_i & ~32'h2. No other strobes.
- All write strobes are single-cycle pulses. flush_o holds for FLUSH_CYCLES cycles total. new_pc_o holds its value during DRAIN.
- During COMMIT/DRAIN, exc_flags_i and int_pend are ignored. They are not queued; the pipeline re-presents them after the flush.
- Interrupts remain level-sensitive and are re-evaluated in IDLE.
- stall_i high in IDLE: no take.
- stall_i high in COMMIT/DRAIN: the FSM still advances, because flush overrides stall.
- rst high in any state: the next edge returns to IDLE with all outputs 0. No partial CP0 write occurs.
- With FLUSH_CYCLES=1, DRAIN is skipped and the FSM goes COMMIT->IDLE.

Test Plan:
1. Overflow: ov=1, pc=0x8000_0100, not in delay slot, status=0x1000_0001 -> next cycle flush_o=1, new_pc=0xBFC00380, epc_o=0x8000_0100, cause_o[6:2]=0x0C, status_o=0x1000_0003; flush_o high 2 cycles total, then busy_o=0.
2. Syscall in delay slot at pc=0x8000_0204 -> epc_o=0x8000_0200, cause_o[31]=1, ExcCode=0x08.
3. int_i[2]=1, status IM4=1, IE=1, EXL=0, plus ri flag in the same cycle -> interrupt wins: ExcCode=0x00, badvaddr_we=0. Repeat with EXL=1 -> RI taken, ExcCode=0x0A.
4. ERET with epc_i=0x8000_0400, status=0x0000_FF03 -> new_pc=0x8000_0400, status_o=0x0000_FF01, epc_we=cause_we=0.
5. AdES at badaddr 0x0000_0003 while stall_i=1 for 3 cycles -> no strobes during stall; on release commit, badvaddr_o=0x3, ExcCode=0x05.
6. rst asserted during DRAIN -> next cycle flush_o=0, busy_o=0; a new syscall after rst drops is taken normally.
